// File: rtl/exp_conv_pkg.sv
// exp_conv_pkg: shared types, exponent LUT contents and parameter helpers
package exp_conv_pkg;

  typedef enum logic {
    NEG_ONES = 1'b0,
    NEG_TWOS = 1'b1
  } neg_mode_e;

  function automatic int clog2(int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // The output must hold the implicit leading 1 plus the sign above the LUT value.
  function automatic bit osz_legal(int osz, int lvsz);
    return osz == lvsz + 2;
  endfunction

  // Fractional part of 2^((a+1)/2^lsz), scaled to lvsz bits, rounded, saturated.
  function automatic int lut_val(int a, int lsz, int lvsz);
    real r;
    int v;
    r = (2.0 ** (real'(a + 1) / real'(1 << lsz)) - 1.0) * real'(1 << lvsz);
    v = $rtoi(r + 0.5);
    return v > (1 << lvsz) - 1 ? (1 << lvsz) - 1 : v;
  endfunction

endpackage

// File: rtl/exp_lut.sv
// exp_lut: registered exponent ROM, contents fixed at elaboration
module exp_lut
  import exp_conv_pkg::*;
#(
  parameter int LSZ  = 8,
  parameter int LVSZ = 10
) (
  input  logic            clk,
  input  logic [LSZ-1:0]  addr_i,
  output logic [LVSZ-1:0] data_o
);

  logic [LVSZ-1:0] rom [2**LSZ];

  for (genvar i = 0; i < 2**LSZ; i++) begin : g_rom
    assign rom[i] = LVSZ'(lut_val(i, LSZ, LVSZ));
  end

  // Synchronous read so the table maps onto block RAM.
  always_ff @(posedge clk) data_o <= rom[addr_i];

endmodule

// File: rtl/exp_conv_mc.sv
// exp_conv_mc: multi-channel pipelined log-to-linear converter with frame mixer
module exp_conv_mc
  import exp_conv_pkg::*;
#(
  parameter int WSZ      = 16,
  parameter int ASZ      = 9,
  parameter int ASH      = 3,
  parameter int LSZ      = 8,
  parameter int LVSZ     = 10,
  parameter int OSZ      = 12,
  parameter int NCH      = 4,
  parameter int NEG_MODE = 0,
  parameter int MIX_EN   = 1,
  localparam int CW      = clog2(NCH),
  localparam int MW      = OSZ + CW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_chan,
  input  logic [WSZ-1:0]       wave,
  input  logic [ASZ-1:0]       atten,
  output logic                 out_valid,
  output logic [CW-1:0]        out_chan,
  output logic signed [OSZ-1:0] out,
  output logic                 mix_valid,
  output logic signed [MW-1:0] mix_out,
  output logic                 mix_err
);

  localparam int SW = WSZ - 1 - LSZ;

  if (!osz_legal(OSZ, LVSZ)) begin : g_bad_osz
    $error("exp_conv_mc: OSZ must equal LVSZ+2");
  end

  logic [WSZ-1:0]  mag_d;
  logic            v1_q, sg1_q, sil1_q;
  logic [CW-1:0]   ch1_q;
  logic [WSZ-2:0]  mag1_q;
  logic            v2_q, sg2_q, sil2_q;
  logic [CW-1:0]   ch2_q;
  logic [SW-1:0]   sh2_q;
  logic [LVSZ-1:0] lut_q;
  logic [OSZ-1:0]  lin, neg, out_d;

  // The extra top bit of mag catches overflow so it can force silence instead of flipping the sign.
  assign mag_d = {1'b0, wave[WSZ-2:0]} + WSZ'({atten, {ASH{1'b0}}});

  // S1: attenuated magnitude, sign and silence flag
  always_ff @(posedge clk) begin
    v1_q   <= reset_n & in_valid;
    ch1_q  <= in_chan;
    sg1_q  <= wave[WSZ-1];
    sil1_q <= (&atten) | mag_d[WSZ-1];
    mag1_q <= mag_d[WSZ-2:0];
  end

  exp_lut #(.LSZ(LSZ), .LVSZ(LVSZ)) u_lut (
    .clk    (clk),
    .addr_i (~mag1_q[LSZ-1:0]),
    .data_o (lut_q)
  );

  // S2: delay the side-band fields alongside the LUT read
  always_ff @(posedge clk) begin
    v2_q   <= reset_n & v1_q;
    ch2_q  <= ch1_q;
    sg2_q  <= sg1_q;
    sil2_q <= sil1_q;
    sh2_q  <= mag1_q[WSZ-2:LSZ];
  end

  // Shifts at or beyond OSZ naturally fall out as zero.
  assign lin   = OSZ'({2'b01, lut_q}) >> sh2_q;
  assign neg   = NEG_MODE == int'(NEG_TWOS) ? -lin : ~lin;
  assign out_d = sil2_q ? '0 : sg2_q ? neg : lin;

  // S3: registered linear output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out       <= '0;
    end else begin
      out_valid <= v2_q;
      out_chan  <= ch2_q;
      out       <= out_d;
    end
  end

  if (MIX_EN != 0) begin : g_mix
    logic [MW-1:0] acc_q, acc_d, ext, mix_d;
    logic [CW-1:0] exp_q, exp_d;
    logic          mv_d, err_d, last;
    // The mixer looks at the S3 next-state so the frame strobe lines up with the last sample.
    assign ext  = {{CW{out_d[OSZ-1]}}, out_d};
    assign last = ch2_q == CW'(NCH - 1);
    // Frame tracking: accumulate in-order channels, restart on any out-of-order sample
    always_comb begin
      acc_d = acc_q;
      exp_d = exp_q;
      mix_d = mix_out;
      mv_d  = 1'b0;
      err_d = mix_err;
      if (v2_q && ch2_q == exp_q) begin
        acc_d = last ? '0 : acc_q + ext;
        exp_d = last ? '0 : exp_q + CW'(1);
        mix_d = last ? acc_q + ext : mix_out;
        mv_d  = last;
      end else if (v2_q) begin
        err_d = 1'b1;
        acc_d = ch2_q == '0 ? ext : '0;
        exp_d = ch2_q == '0 ? CW'(1) : '0;
      end
    end
    // Frame registers; mix_out holds between strobes, mix_err is sticky
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        acc_q     <= '0;
        exp_q     <= '0;
        mix_out   <= '0;
        mix_valid <= 1'b0;
        mix_err   <= 1'b0;
      end else begin
        acc_q     <= acc_d;
        exp_q     <= exp_d;
        mix_out   <= mix_d;
        mix_valid <= mv_d;
        mix_err   <= err_d;
      end
    end
  end else begin : g_nomix
    assign mix_valid = 1'b0;
    assign mix_out   = '0;
    assign mix_err   = 1'b0;
  end

endmodule

// File: tb/tb_exp_conv_mc.sv
// tb_exp_conv_mc: random and directed check of exp_conv_mc against a behavioural model
module tb_exp_conv_mc;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_chan = '0;
  logic [15:0] wave = '0;
  logic [8:0]  atten = '0;
  logic        out_valid, mix_valid, mix_err;
  logic [1:0]  out_chan;
  logic [11:0] out;
  logic [13:0] mix_out;
  logic        ov2, mv2, me2;
  logic [1:0]  oc2;
  logic [11:0] o2;
  logic [13:0] mo2;

  always #5 clk = ~clk;

  exp_conv_mc u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_chan(in_chan),
    .wave(wave), .atten(atten), .out_valid(out_valid), .out_chan(out_chan),
    .out(out), .mix_valid(mix_valid), .mix_out(mix_out), .mix_err(mix_err)
  );

  exp_conv_mc #(.NEG_MODE(1), .MIX_EN(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_chan(in_chan),
    .wave(wave), .atten(atten), .out_valid(ov2), .out_chan(oc2),
    .out(o2), .mix_valid(mv2), .mix_out(mo2), .mix_err(me2)
  );

  typedef struct {int due; int ch; int v1; int v2;} exp_t;

  exp_t q[$];
  int   n_vec = 0, n_bad = 0, cyc = 0;
  int   m_acc = 0, m_exp = 0, m_mo = 0;
  bit   m_err = 1'b0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int ref_lut(int a);
    real r;
    int  v;
    r = (2.0 ** (real'(a + 1) / 256.0) - 1.0) * 1024.0;
    v = $rtoi(r + 0.5);
    return v > 1023 ? 1023 : v;
  endfunction

  function automatic int ref_out(int w, int a, bit twos);
    int mag, sh, lin;
    mag = (w & 'h7FFF) + a * 8;
    if (a == 511 || mag > 'h7FFF) return 0;
    sh  = mag / 256;
    lin = sh >= 12 ? 0 : (1024 + ref_lut(255 - mag % 256)) / (1 << sh);
    if ((w & 'h8000) == 0) return lin;
    return twos ? (4096 - lin) % 4096 : 4095 - lin;
  endfunction

  task automatic tick(bit rn, bit v, int ch, int w, int a);
    bit   ev = 1'b0, emv = 1'b0;
    int   sv;
    exp_t e;
    e = '{0, 0, 0, 0};
    reset_n  = rn;
    in_valid = v;
    in_chan  = 2'(ch);
    wave     = 16'(w);
    atten    = 9'(a);
    @(posedge clk);
    cyc++;
    if (!rn) begin
      q.delete();
      m_acc = 0;
      m_exp = 0;
      m_mo  = 0;
      m_err = 1'b0;
    end else begin
      if (v) q.push_back('{cyc + 2, ch, ref_out(w, a, 1'b0), ref_out(w, a, 1'b1)});
      if (q.size() > 0 && q[0].due == cyc) begin
        e  = q.pop_front();
        ev = 1'b1;
        sv = e.v1 >= 2048 ? e.v1 - 4096 : e.v1;
        if (e.ch == m_exp) begin
          if (e.ch == NCH - 1) begin
            m_mo  = (m_acc + sv) & 'h3FFF;
            emv   = 1'b1;
            m_acc = 0;
            m_exp = 0;
          end else begin
            m_acc += sv;
            m_exp++;
          end
        end else begin
          m_err = 1'b1;
          m_acc = e.ch == 0 ? sv : 0;
          m_exp = e.ch == 0 ? 1 : 0;
        end
      end
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_valid_n2", 32'(ov2), 32'(ev));
    if (ev) begin
      chk("out_chan", 32'(out_chan), 32'(e.ch));
      chk("out", 32'(out), 32'(e.v1));
      chk("out_n2", 32'(o2), 32'(e.v2));
    end
    chk("mix_valid", 32'(mix_valid), 32'(emv));
    chk("mix_out", 32'(mix_out), 32'(m_mo));
    chk("mix_err", 32'(mix_err), 32'(m_err));
    chk("mix_n2", 32'({mv2, me2, mo2}), 32'(0));
    if (!rn) begin
      chk("rst_out", 32'(out), 32'(0));
      chk("rst_chan", 32'(out_chan), 32'(0));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    int seq = 0;
    tick(1'b0, 1'b0, 0, 0, 0);
    tick(1'b0, 1'b1, 0, 0, 0);
    // directed: latency, positive/negative values, silence and overflow
    tick(1'b1, 1'b1, 0, 'h0000, 0);
    idle(1);
    chk("t1_early", 32'(out_valid), 32'(0));
    idle(1);
    chk("t1_out", 32'(out), 32'h7FF);
    tick(1'b1, 1'b1, 1, 'h0100, 0);
    idle(2);
    chk("t2_pos", 32'(out), 32'h3FF);
    tick(1'b1, 1'b1, 2, 'h8100, 0);
    idle(2);
    chk("t2_neg_ones", 32'(out), 32'hC00);
    chk("t2_neg_twos", 32'(o2), 32'hC01);
    tick(1'b1, 1'b1, 3, 'h1234, 'h1FF);
    idle(2);
    chk("t3_silent", 32'(out), 32'h0);
    tick(1'b1, 1'b1, 0, 'h7F00, 'h100);
    idle(2);
    chk("t3_ovf", 32'(out), 32'h0);
    // directed: back-to-back frame
    tick(1'b0, 1'b0, 0, 0, 0);
    for (int c = 0; c < NCH; c++) tick(1'b1, 1'b1, c, 0, 0);
    idle(2);
    chk("t4_mix_valid", 32'(mix_valid), 32'h1);
    chk("t4_mix_out", 32'(mix_out), 32'h1FFC);
    // directed: frame violation then recovery
    tick(1'b1, 1'b1, 0, 0, 0);
    tick(1'b1, 1'b1, 2, 0, 0);
    idle(2);
    chk("t5_err", 32'(mix_err), 32'h1);
    for (int c = 0; c < NCH; c++) tick(1'b1, 1'b1, c, 0, 0);
    idle(2);
    chk("t5_mix_out", 32'(mix_out), 32'h1FFC);
    chk("t5_err_sticky", 32'(mix_err), 32'h1);
    // directed: reset with samples in flight
    tick(1'b1, 1'b1, 0, 0, 0);
    tick(1'b1, 1'b1, 1, 0, 0);
    tick(1'b0, 1'b0, 0, 0, 0);
    chk("t6_err_clr", 32'(mix_err), 32'h0);
    idle(3);
    // random traffic, mostly in-order frames with occasional disorder and resets
    for (int i = 0; i < 3000; i++) begin
      bit rn, v;
      int ch, w, a;
      rn = $urandom_range(199) != 0;
      v  = $urandom_range(3) != 0;
      ch = $urandom_range(11) == 0 ? int'($urandom_range(3)) : seq;
      w  = $urandom_range(7) == 0 ? int'($urandom_range(65535))
                                  : int'(($urandom & 'h80FF) | ($urandom_range(13) << 8));
      a  = $urandom_range(3) == 0 ? int'($urandom_range(511)) : int'($urandom_range(15));
      if (!rn) seq = 0;
      else if (v) seq = (ch + 1) % NCH;
      tick(rn, v, ch, w, a);
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
